// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared types and defaults for the program-counter sequencer.
//   - state_t          : sequencer FSM states
//   - *_DEF            : default widths, halt PC and memory timeout
//   - is_active_state  : true for states that count as active machine cycles
package pc_seq_pkg;

  localparam int unsigned PC_W_DEF        = 32'd10;
  localparam int unsigned OFF_W_DEF       = 32'd7;
  localparam int unsigned HALT_PC_DEF     = 32'd63;
  localparam int unsigned MEM_TIMEOUT_DEF = 32'd15;
  localparam int unsigned CNT_W_DEF       = 32'd16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_ADVANCE  = 3'd4,
    ST_HALTED   = 3'd5
  } state_t;

  // Cycles spent in these states are charged to cycle_count and keep busy high.
  function automatic logic is_active_state(input state_t s);
    is_active_state = (s == ST_FETCH) || (s == ST_EXEC) ||
                      (s == ST_MEM_WAIT) || (s == ST_ADVANCE);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     CLK  in   clock
//     init in   synchronous active-high clear
//     inc  in   count enable for this cycle
//     q    out  CNT_W count value
module sat_counter #(
  parameter int unsigned CNT_W = 32'd16
) (
  input  logic             CLK,
  input  logic             init,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: cleared by init, advances on inc until all-ones.
  always_ff @(posedge CLK) begin
    if (init) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != '1)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q = cnt_r;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle control FSM that paces fetch/execute, stalls on data memory,
//   issues a one-cycle pc_step with jump/branch qualifiers, and stops the machine
//   on a halt opcode, PC overrun or memory timeout. All outputs are registers
//   loaded from the next state, so each output describes the state it is in.
//   Ports:
//     CLK, init                       clock and synchronous active-high reset
//     start                           begin execution (IDLE only)
//     pc                              current PC, checked against HALT_PC in FETCH
//     is_jump/is_branch/branch_cond   decode and ALU flags, sampled in EXEC
//     jump_off, is_mem, is_halt       decode fields, sampled in EXEC
//     mem_ack                         data memory completion
//     ir_load                         high during EXEC (instruction register load)
//     mem_req                         high during MEM_WAIT
//     pc_step/jump_en/branch_en/counter/reg_we   ADVANCE controls
//     busy, halt, fault               status (halt and fault sticky until init)
//     instr_count, cycle_count        saturating perf counters
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W        = PC_W_DEF,
  parameter int unsigned OFF_W       = OFF_W_DEF,
  parameter int unsigned HALT_PC     = HALT_PC_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             init,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             branch_cond,
  input  logic [OFF_W-1:0] jump_off,
  input  logic             is_mem,
  input  logic             is_halt,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             mem_req,
  output logic             reg_we,
  output logic             pc_step,
  output logic             jump_en,
  output logic             branch_en,
  output logic [OFF_W-1:0] counter,
  output logic             busy,
  output logic             halt,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned      WAIT_W    = $clog2(MEM_TIMEOUT + 32'd1);
  localparam logic [PC_W-1:0]  HALT_PC_V = PC_W'(HALT_PC);
  // Wait count seen in the last MEM_WAIT cycle before a timeout.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 32'd1);

  state_t            state_r;
  state_t            nxt_s;
  logic [WAIT_W-1:0] wait_r;
  logic              lat_jump_r;
  logic              lat_branch_r;
  logic              lat_taken_r;
  logic [OFF_W-1:0]  lat_off_r;
  logic              jump_nx_s;
  logic              branch_nx_s;
  logic              taken_nx_s;
  logic [OFF_W-1:0]  off_nx_s;
  logic              timeout_s;
  logic              adv_nx_s;

  logic             ir_load_r;
  logic             mem_req_r;
  logic             reg_we_r;
  logic             pc_step_r;
  logic             jump_en_r;
  logic             branch_en_r;
  logic [OFF_W-1:0] counter_r;
  logic             busy_r;
  logic             halt_r;
  logic             fault_r;

  // Next-state decode.
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) nxt_s = ST_FETCH;
        else       nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (pc > HALT_PC_V) nxt_s = ST_HALTED;
        else                nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        // Halt beats every other decode flag.
        if (is_halt)     nxt_s = ST_HALTED;
        else if (is_mem) nxt_s = ST_MEM_WAIT;
        else             nxt_s = ST_ADVANCE;
      end
      ST_MEM_WAIT: begin
        // An ack in the final allowed cycle still counts as success.
        if (mem_ack)                  nxt_s = ST_ADVANCE;
        else if (wait_r == WAIT_LAST) nxt_s = ST_HALTED;
        else                          nxt_s = ST_MEM_WAIT;
      end
      ST_ADVANCE: nxt_s = ST_FETCH;
      ST_HALTED:  nxt_s = ST_HALTED;
      default:    nxt_s = ST_IDLE;
    endcase
  end

  // Decode fields as they will be held after this edge: taken straight from the
  // inputs while leaving EXEC so a direct EXEC->ADVANCE sees them in time.
  always_comb begin
    jump_nx_s   = lat_jump_r;
    branch_nx_s = lat_branch_r;
    taken_nx_s  = lat_taken_r;
    off_nx_s    = lat_off_r;
    if (state_r == ST_EXEC) begin
      jump_nx_s   = is_jump;
      branch_nx_s = is_branch;
      taken_nx_s  = is_branch & branch_cond;
      off_nx_s    = jump_off;
    end else begin
      jump_nx_s   = lat_jump_r;
      branch_nx_s = lat_branch_r;
      taken_nx_s  = lat_taken_r;
      off_nx_s    = lat_off_r;
    end
  end

  assign timeout_s = (state_r == ST_MEM_WAIT) && !mem_ack && (wait_r == WAIT_LAST);
  assign adv_nx_s  = (nxt_s == ST_ADVANCE);

  // State, decode latches, wait counter and registered Moore outputs.
  always_ff @(posedge CLK) begin
    if (init) begin
      state_r      <= ST_IDLE;
      wait_r       <= '0;
      lat_jump_r   <= 1'b0;
      lat_branch_r <= 1'b0;
      lat_taken_r  <= 1'b0;
      lat_off_r    <= '0;
      ir_load_r    <= 1'b0;
      mem_req_r    <= 1'b0;
      reg_we_r     <= 1'b0;
      pc_step_r    <= 1'b0;
      jump_en_r    <= 1'b0;
      branch_en_r  <= 1'b0;
      counter_r    <= '0;
      busy_r       <= 1'b0;
      halt_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= nxt_s;
      lat_jump_r   <= jump_nx_s;
      lat_branch_r <= branch_nx_s;
      lat_taken_r  <= taken_nx_s;
      lat_off_r    <= off_nx_s;
      // Held at zero outside MEM_WAIT, which clears it on every entry.
      if (state_r == ST_MEM_WAIT) wait_r <= wait_r + WAIT_W'(1);
      else                        wait_r <= '0;
      ir_load_r    <= (nxt_s == ST_EXEC);
      mem_req_r    <= (nxt_s == ST_MEM_WAIT);
      pc_step_r    <= adv_nx_s;
      jump_en_r    <= adv_nx_s & jump_nx_s;
      // A decoded jump wins over a taken branch.
      branch_en_r  <= adv_nx_s & taken_nx_s & ~jump_nx_s;
      counter_r    <= adv_nx_s ? off_nx_s : '0;
      reg_we_r     <= adv_nx_s & ~(jump_nx_s | branch_nx_s);
      busy_r       <= is_active_state(nxt_s);
      halt_r       <= (nxt_s == ST_HALTED);
      fault_r      <= fault_r | timeout_s;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .CLK  (CLK),
    .init (init),
    .inc  (state_r == ST_ADVANCE),
    .q    (instr_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .CLK  (CLK),
    .init (init),
    .inc  (is_active_state(state_r)),
    .q    (cycle_count)
  );

  assign ir_load   = ir_load_r;
  assign mem_req   = mem_req_r;
  assign reg_we    = reg_we_r;
  assign pc_step   = pc_step_r;
  assign jump_en   = jump_en_r;
  assign branch_en = branch_en_r;
  assign counter   = counter_r;
  assign busy      = busy_r;
  assign halt      = halt_r;
  assign fault     = fault_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. Each instruction is turned into the
//   cycle-by-cycle list of expected output vectors it should produce, built from
//   the instruction-level rules (latencies, qualifier rules, timeout length), and
//   the DUT is compared against that list every cycle along with perf counters.
module tb_pc_sequencer;

  localparam int PC_W = 10;
  localparam int OFF_W = 7;
  localparam int CNT_W = 16;
  localparam int TMO = 15;
  localparam int HALT_PC = 63;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic init = 1'b1;
  logic start = 1'b0;
  logic [PC_W-1:0] pc = '0;
  logic is_jump = 1'b0, is_branch = 1'b0, branch_cond = 1'b0;
  logic [OFF_W-1:0] jump_off = '0;
  logic is_mem = 1'b0, is_halt = 1'b0, mem_ack = 1'b0;
  logic ir_load, mem_req, reg_we, pc_step, jump_en, branch_en, busy, halt, fault;
  logic [OFF_W-1:0] counter;
  logic [CNT_W-1:0] instr_count, cycle_count;

  pc_sequencer dut (
    .CLK(CLK), .init(init), .start(start), .pc(pc),
    .is_jump(is_jump), .is_branch(is_branch), .branch_cond(branch_cond),
    .jump_off(jump_off), .is_mem(is_mem), .is_halt(is_halt), .mem_ack(mem_ack),
    .ir_load(ir_load), .mem_req(mem_req), .reg_we(reg_we), .pc_step(pc_step),
    .jump_en(jump_en), .branch_en(branch_en), .counter(counter),
    .busy(busy), .halt(halt), .fault(fault),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  logic [15:0] obs;
  assign obs = {ir_load, mem_req, reg_we, pc_step, jump_en, branch_en, counter, busy, halt, fault};

  int n_pass = 0;
  int n_total = 0;
  int m_instr = 0;
  int m_cyc = 0;
  bit m_fault = 0;

  function automatic logic [15:0] mk(input bit ir, mr, we, st, je, be,
                                     input logic [6:0] c, input bit bz, hl, fl);
    mk = {ir, mr, we, st, je, be, c, bz, hl, fl};
  endfunction

  // Run one instruction from its FETCH cycle; ends in the next FETCH or in HALTED.
  task automatic exec_instr(input string nm, input logic [PC_W-1:0] a_pc,
                            input bit j, br, cond, input logic [6:0] off,
                            input bit mem, hlt, input int ack_at, output bit halted);
    logic [15:0] exp_q[$];
    bit ack_q[$];
    bit act_q[$];
    bit ret_q[$];
    bit tmo;
    tmo = 0;
    halted = 0;
    exp_q.push_back(mk(0,0,0,0,0,0,7'd0,1,0,m_fault)); ack_q.push_back(0);
    act_q.push_back(1); ret_q.push_back(0);
    if (int'(a_pc) > HALT_PC) begin
      halted = 1;
    end else begin
      exp_q.push_back(mk(1,0,0,0,0,0,7'd0,1,0,m_fault)); ack_q.push_back(0);
      act_q.push_back(1); ret_q.push_back(0);
      if (hlt) begin
        halted = 1;
      end else begin
        if (mem) begin
          for (int k = 1; k <= TMO; k++) begin
            exp_q.push_back(mk(0,1,0,0,0,0,7'd0,1,0,m_fault)); ack_q.push_back(k == ack_at);
            act_q.push_back(1); ret_q.push_back(0);
            if (k == ack_at) break;
            if (k == TMO) tmo = 1;
          end
        end
        if (tmo) begin
          halted = 1;
        end else begin
          exp_q.push_back(mk(0,0,!(j|br),1,j,br&cond&!j,off,1,0,m_fault)); ack_q.push_back(0);
          act_q.push_back(1); ret_q.push_back(1);
        end
      end
    end
    if (halted) begin
      exp_q.push_back(mk(0,0,0,0,0,0,7'd0,0,1,m_fault|tmo)); ack_q.push_back(0);
      act_q.push_back(0); ret_q.push_back(0);
    end
    pc = a_pc; is_jump = j; is_branch = br; branch_cond = cond;
    jump_off = off; is_mem = mem; is_halt = hlt;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ack = ack_q[i];
      n_total++;
      if (obs !== exp_q[i])
        $display("FAIL %s outputs cyc%0d: got %h expected %h", nm, i, obs, exp_q[i]);
      else n_pass++;
      n_total++;
      if ({instr_count, cycle_count} !== {16'(m_instr), 16'(m_cyc)})
        $display("FAIL %s counters cyc%0d: got %0d/%0d expected %0d/%0d", nm, i,
                 instr_count, cycle_count, m_instr, m_cyc);
      else n_pass++;
      if (act_q[i] && m_cyc < 65535) m_cyc++;
      if (ret_q[i] && m_instr < 65535) m_instr++;
      if (!(halted && i == exp_q.size() - 1)) begin
        @(posedge CLK); #1;
      end
    end
    mem_ack = 0;
    if (halted) m_fault = m_fault | tmo;
  endtask

  task automatic do_init();
    init = 1; start = 1'($urandom); mem_ack = 1'($urandom); is_mem = 1'($urandom);
    @(posedge CLK); #1;
    init = 0; start = 0; mem_ack = 0; is_mem = 0; is_jump = 0; is_branch = 0;
    branch_cond = 0; is_halt = 0; jump_off = '0; pc = '0;
    m_instr = 0; m_cyc = 0; m_fault = 0;
  endtask

  task automatic do_start();
    start = 1;
    @(posedge CLK); #1;
    start = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      init = 1; start = 1'($urandom); mem_ack = 1'($urandom); is_halt = 1'($urandom);
      @(posedge CLK); #1;
      n_total++;
      if ({obs, instr_count, cycle_count} !== 48'd0)
        $display("FAIL reset cyc%0d: got %h/%0d/%0d expected 0", i, obs, instr_count, cycle_count);
      else n_pass++;
    end
    init = 0; start = 0; mem_ack = 0; is_halt = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      n_total++;
      if (obs !== 16'd0) $display("FAIL idle_hold: got %h expected 0000", obs);
      else n_pass++;
    end
  endtask

  task automatic test_alu();
    bit h;
    do_init(); do_start();
    for (int i = 0; i < 3; i++) exec_instr("alu", 10'(i), 0, 0, 0, 7'd0, 0, 0, 0, h);
    n_total++;
    if (instr_count !== 16'd3 || cycle_count !== 16'd9)
      $display("FAIL alu_counts: got %0d/%0d expected 3/9", instr_count, cycle_count);
    else n_pass++;
  endtask

  task automatic test_jump();
    bit h;
    exec_instr("jump_m3", 10'd3, 1, 0, 0, 7'h7D, 0, 0, 0, h);
    exec_instr("jump_and_branch", 10'd4, 1, 1, 1, 7'h05, 0, 0, 0, h);
    for (int i = 0; i < 4; i++)
      exec_instr("jump_rand", 10'($urandom_range(0, 63)), 1, 1'($urandom), 1'($urandom),
                 7'($urandom), 0, 0, 0, h);
  endtask

  task automatic test_branch();
    bit h;
    exec_instr("branch_taken", 10'd10, 0, 1, 1, 7'h11, 0, 0, 0, h);
    exec_instr("branch_not_taken", 10'd11, 0, 1, 0, 7'h22, 0, 0, 0, h);
  endtask

  task automatic test_mem();
    bit h;
    exec_instr("mem_ack4", 10'd20, 0, 0, 0, 7'd0, 1, 0, 4, h);
    exec_instr("mem_ack1", 10'd21, 0, 0, 0, 7'd0, 1, 0, 1, h);
    exec_instr("mem_ack15", 10'd22, 1, 0, 0, 7'h3F, 1, 0, 15, h);
    for (int i = 0; i < 3; i++)
      exec_instr("mem_rand", 10'd23, 0, 1, 1'($urandom), 7'd0, 1, 0, $urandom_range(1, 14), h);
    exec_instr("mem_timeout", 10'd24, 0, 0, 0, 7'd0, 1, 0, 0, h);
    n_total++;
    if (!h || halt !== 1'b1 || fault !== 1'b1)
      $display("FAIL timeout_status: got halt=%b fault=%b expected 1/1", halt, fault);
    else n_pass++;
    start = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      n_total++;
      if (obs !== mk(0,0,0,0,0,0,7'd0,0,1,1))
        $display("FAIL start_in_halted_fault: got %h expected %h", obs, mk(0,0,0,0,0,0,7'd0,0,1,1));
      else n_pass++;
    end
    start = 0;
  endtask

  task automatic test_halt();
    bit h;
    do_init(); do_start();
    exec_instr("pc_overrun", 10'd64, 0, 0, 0, 7'd0, 0, 0, 0, h);
    do_init(); do_start();
    exec_instr("pre_halt", 10'd0, 0, 0, 0, 7'd0, 0, 0, 0, h);
    exec_instr("halt_op", 10'd1, 1, 1, 1, 7'h12, 1, 1, 0, h);
    start = 1;
    repeat (3) @(posedge CLK);
    #1;
    start = 0;
    n_total++;
    if (instr_count !== 16'd1 || halt !== 1'b1 || busy !== 1'b0 || fault !== 1'b0)
      $display("FAIL halt_op_status: got instr=%0d halt=%b busy=%b fault=%b expected 1/1/0/0",
               instr_count, halt, busy, fault);
    else n_pass++;
  endtask

  task automatic test_init_mid_mem();
    do_init(); do_start();
    pc = 10'd5; is_mem = 1;
    repeat (2) @(posedge CLK);
    #1;
    n_total++;
    if (mem_req !== 1'b1) $display("FAIL mid_mem_entry: got mem_req=%b expected 1", mem_req);
    else n_pass++;
    @(posedge CLK); #1;
    init = 1;
    @(posedge CLK); #1;
    init = 0; is_mem = 0;
    n_total++;
    if ({obs, instr_count, cycle_count} !== 48'd0)
      $display("FAIL init_mid_mem: got %h/%0d/%0d expected 0", obs, instr_count, cycle_count);
    else n_pass++;
    @(posedge CLK); #1;
    n_total++;
    if (obs !== 16'd0) $display("FAIL idle_after_init: got %h expected 0000", obs);
    else n_pass++;
    m_instr = 0; m_cyc = 0; m_fault = 0;
  endtask

  task automatic test_random();
    bit h;
    int ack;
    do_init(); do_start();
    for (int i = 0; i < 60; i++) begin
      ack = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 15);
      exec_instr("random",
                 ($urandom_range(0, 29) == 0) ? 10'($urandom_range(64, 1023)) : 10'($urandom_range(0, 63)),
                 1'($urandom), 1'($urandom), 1'($urandom), 7'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0), ack, h);
      if (h) begin
        do_init(); do_start();
      end
    end
  endtask

  task automatic test_saturation();
    do_init(); do_start();
    repeat (65540) @(posedge CLK);
    #1;
    n_total++;
    if (cycle_count !== 16'hFFFF || instr_count !== 16'd21846)
      $display("FAIL saturate: got %0d/%0d expected 21846/65535", instr_count, cycle_count);
    else n_pass++;
    repeat (6) @(posedge CLK);
    #1;
    n_total++;
    if (cycle_count !== 16'hFFFF || instr_count !== 16'd21848)
      $display("FAIL saturate_hold: got %0d/%0d expected 21848/65535", instr_count, cycle_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jump();
    test_branch();
    test_mem();
    test_halt();
    test_init_mid_mem();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
